// File: rtl/rv_skid_fifo_if.sv
// Ready/valid beat channel carrying WIDTH-bit data.
// The master side drives dat/valid, and the slave side drives ready.
interface rv_skid_fifo_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] dat;
   logic             valid;
   logic             ready;

   modport master (output dat, output valid, input ready);
   modport slave  (input dat, input valid, output ready);
endinterface

// File: rtl/rv_skid_fifo.sv
// Registered ready/valid FIFO. No combinational path from i.ready to t.ready, and no bypass.
// Optional occupancy/throughput counters are enabled by defining RV_SKID_FIFO_STATS_EN.
module rv_skid_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic clock,
   input  logic reset,
   rv_skid_fifo_if.slave  t,
   rv_skid_fifo_if.master i
`ifdef RV_SKID_FIFO_STATS_EN
   ,
   output logic [31:0]                  st_in_count,
   output logic [31:0]                  st_out_count,
   output logic [$clog2(DEPTH+1)-1:0]   st_max_level
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    count;
   logic             push, pop;

   // Both handshakes decode from registered count only, so there is no ready chaining.
   assign t.ready = (count != FULL);
   assign i.valid = (count != '0);
   assign i.dat   = mem[rd_ptr];

   assign push = t.valid && (count != FULL);
   assign pop  = (count != '0) && i.ready;

   // The storage array is deliberately left uncleared on reset.
   always_ff @(posedge clock) begin
      if (!reset && push) mem[wr_ptr] <= t.dat;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

`ifdef RV_SKID_FIFO_STATS_EN
   // The high-watermark tracks registered count, so it trails a push by one cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         st_in_count  <= '0;
         st_out_count <= '0;
         st_max_level <= '0;
      end else begin
         if (push) st_in_count  <= st_in_count + 32'd1;
         if (pop)  st_out_count <= st_out_count + 32'd1;
         if (count > st_max_level) st_max_level <= count;
      end
   end
`endif

endmodule

// File: tb/tb_rv_skid_fifo.sv
// Scoreboard bench for rv_skid_fifo: stimulus pushes expected beats into a queue,
// and a negedge monitor pops and compares every beat the DUT issues.
module tb_rv_skid_fifo;
   localparam int WIDTH = 32;
   localparam int DEPTH = 4;

   logic clock = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_pass = 0;
   int   n_total = 0;
   int   n_rx = 0;
   logic [WIDTH-1:0] exp_q[$];

   rv_skid_fifo_if #(.WIDTH(WIDTH)) t_if ();
   rv_skid_fifo_if #(.WIDTH(WIDTH)) i_if ();

`ifdef RV_SKID_FIFO_STATS_EN
   logic [31:0]                st_in_count, st_out_count;
   logic [$clog2(DEPTH+1)-1:0] st_max_level;
`endif

   rv_skid_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clock (clock),
      .reset (reset),
      .t     (t_if),
      .i     (i_if)
`ifdef RV_SKID_FIFO_STATS_EN
      ,
      .st_in_count  (st_in_count),
      .st_out_count (st_out_count),
      .st_max_level (st_max_level)
`endif
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: a pop happens at the next posedge whenever valid && ready here.
   always @(negedge clock) begin
      if (!reset && i_if.valid && i_if.ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_beat", i_if.dat, 32'hxxxxxxxx);
         end else begin
            check("beat_data", i_if.dat, exp_q.pop_front());
            n_rx++;
         end
      end
   end

   // Offer one beat and hold it until accepted; the expected value is queued at acceptance.
   task automatic send(input logic [WIDTH-1:0] d);
      int n = 0;
      t_if.valid = 1'b1;
      t_if.dat   = d;
      while (n < 100) begin
         @(negedge clock);
         if (t_if.ready) begin
            exp_q.push_back(d);
            @(posedge clock);
            #1;
            t_if.valid = 1'b0;
            return;
         end
         n++;
      end
      check("send_timeout", 32'd0, 32'd1);
      t_if.valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge clock);
         n++;
      end
      @(posedge clock);
      #1;
      check(name, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b1;
      repeat (cycles) @(posedge clock);
      #1;
      reset = 1'b0;
      exp_q.delete();
   endtask

   bit alt_done;
   int t0;

   initial begin
      reset      = 1'b1;
      t_if.valid = 1'b0;
      t_if.dat   = '0;
      i_if.ready = 1'b0;

      // Reset defaults
      do_reset(3);
      check("rst_t_ready", 32'(t_if.ready), 32'd1);
      check("rst_i_valid", 32'(i_if.valid), 32'd0);
`ifdef RV_SKID_FIFO_STATS_EN
      check("rst_st_in", st_in_count, 32'd0);
      check("rst_st_out", st_out_count, 32'd0);
      check("rst_st_max", 32'(st_max_level), 32'd0);
`endif

      // Single beat: visible right after the push edge, popped at the next edge
      i_if.ready = 1'b1;
      send(32'hDEADBEEF);
      check("single_valid", 32'(i_if.valid), 32'd1);
      check("single_dat", i_if.dat, 32'hDEADBEEF);
      @(posedge clock);
      #1;
      check("single_empty", 32'(i_if.valid), 32'd0);

      // Fill and drain
      i_if.ready = 1'b0;
      for (int k = 1; k <= 4; k++) send(32'(k));
      check("full_t_ready", 32'(t_if.ready), 32'd0);
      check("full_head", i_if.dat, 32'd1);
      t_if.valid = 1'b1;
      t_if.dat   = 32'd5;
      repeat (3) begin
         @(negedge clock);
         check("stall_t_ready", 32'(t_if.ready), 32'd0);
      end
      @(posedge clock);
      #1;
      i_if.ready = 1'b1;
      @(negedge clock);
      check("full_during_pop", 32'(t_if.ready), 32'd0);
      @(posedge clock);
      #1;
      check("refill_t_ready", 32'(t_if.ready), 32'd1);
      send(32'd5);
      drain("fill_drain_done");

      // Wrap-around at full rate: one beat per cycle
      i_if.ready = 1'b1;
      n_rx = 0;
      t0 = cyc;
      for (int k = 0; k < 10; k++) send(32'h100 + 32'(k));
      check("wrap_cycles", 32'(cyc - t0), 32'd10);
      drain("wrap_done");
      check("wrap_rx", 32'(n_rx), 32'd10);

      // Alternating consumer backpressure, 100 beats
      do_reset(1);
      n_rx = 0;
      alt_done = 1'b0;
      i_if.ready = 1'b0;
      fork
         begin
            while (!alt_done) begin
               @(posedge clock);
               #1;
               i_if.ready = ~i_if.ready;
            end
         end
         begin
            for (int k = 0; k < 100; k++) send(32'h1000 + 32'(k));
            drain("alt_done");
            alt_done = 1'b1;
         end
      join
      check("alt_rx", 32'(n_rx), 32'd100);
`ifdef RV_SKID_FIFO_STATS_EN
      check("alt_st_in", st_in_count, 32'd100);
      check("alt_st_out", st_out_count, 32'd100);
      check("alt_st_max", 32'(st_max_level), 32'd4);
`endif

      // Reset mid-stream with a beat offered during reset
      i_if.ready = 1'b0;
      for (int k = 0; k < 3; k++) send(32'hA0 + 32'(k));
      check("held_valid", 32'(i_if.valid), 32'd1);
      t_if.valid = 1'b1;
      t_if.dat   = 32'hBAD0BAD0;
      do_reset(1);
      t_if.valid = 1'b0;
      check("midrst_i_valid", 32'(i_if.valid), 32'd0);
      check("midrst_t_ready", 32'(t_if.ready), 32'd1);
      repeat (2) @(posedge clock);
      #1;
      check("midrst_not_stored", 32'(i_if.valid), 32'd0);
`ifdef RV_SKID_FIFO_STATS_EN
      check("midrst_st_max", 32'(st_max_level), 32'd0);
      check("midrst_st_in", st_in_count, 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/rv_skid_fifo.md
# rv_skid_fifo

Parameterized ready/valid FIFO stage placed directly downstream of an `rv_initiator_bfm`. It accepts beats on a target-side port and re-issues them in order on an initiator-side port. This decouples the BFM from a consumer's backpressure pattern. The block has no combinational path from downstream `i_ready` to upstream `t_ready`, so it can be chained freely in smoke benches.

## Interface
- `WIDTH`, 32, data width in bits.
- `DEPTH`, 4, entry count; must be a power of two and ≥ 2.

Ports:
- `clock`  in  1  — clock; all state updates on the rising edge.
- `reset`  in  1  — reset; synchronous, active-high.
- `t_dat`  in  WIDTH  — upstream data.
- `t_valid`  in  1  — upstream beat valid.
- `t_ready`  out  1  — block can accept a beat.
- `i_dat`  out  WIDTH  — downstream data (head entry).
- `i_valid`  out  1  — head entry valid.
- `i_ready`  in  1  — downstream accepts the head.
- `st_in_count`  out  32  — beats accepted (only with `RV_SKID_FIFO_STATS_EN`).
- `st_out_count`  out  32  — beats issued (only with `RV_SKID_FIFO_STATS_EN`).
- `st_max_level`  out  $clog2(DEPTH+1)  — occupancy high-watermark (only with `RV_SKID_FIFO_STATS_EN`).

## Operation
- **Storage**
  - `DEPTH`×`WIDTH` register array.
  - Write pointer `wr_ptr` and read pointer `rd_ptr`, each $clog2(DEPTH) bits, wrapping naturally from `DEPTH-1` to 0.
  - Occupancy `count`, $clog2(DEPTH+1) bits, range 0..`DEPTH`.
- **Push/pop definitions**
  - push = `t_valid && t_ready`.
  - pop = `i_valid && i_ready`.
- **Output decode**
  - `t_ready` = (`count != DEPTH`), decoded only from `count`.
  - `i_valid` = (`count != 0`).
  - `i_dat` = `mem[rd_ptr]`.
- **Update rules**
  - push: `mem[wr_ptr] <= t_dat`; `wr_ptr` increments.
  - pop: `rd_ptr` increments.
  - `count` change: push only +1; pop only −1; both or neither unchanged.
- **Ordering:** strict FIFO; no beats are dropped or duplicated.
- **Full state:** `t_ready` = 0, even if a pop happens in the same cycle. No push-through-on-pop.
- **Empty state:** `i_valid` = 0. There is no bypass; a beat always spends at least one cycle in storage.
- **`i_dat` when `i_valid` = 0:** don't-care, but the array is not cleared on reset.
- **Reset**
  - Applies to `wr_ptr`, `rd_ptr`, `count` and the stats registers.
  - Takes priority over a push or pop in the same cycle.
  - Reset mid-stream discards all held beats.
- **Reset values:** `t_ready` = 1, `i_valid` = 0, all stats = 0.

## Timing
- **Latency:** a beat pushed at edge N has `i_valid` = 1 with that data after edge N, and can pop at edge N+1. Minimum latency is 1 cycle.
- **Throughput:** one beat per cycle in steady state when `count` is between 1 and `DEPTH-1` and both sides are active.
- **Refill after full:** `t_ready` rises the cycle after the first pop from full.
- **Protocol rules**
  - Once `i_valid` is asserted, it and `i_dat` stay stable until pop.
  - The upstream side obeys the same rule; the block does not check it.

## Configuration
- **`RV_SKID_FIFO_STATS_EN` defined**
  - The stats ports and counters exist.
  - `st_in_count` increments on push and `st_out_count` increments on pop; both are 32-bit and wrap.
  - `st_max_level` is the maximum registered `count` value since reset.
- **`RV_SKID_FIFO_STATS_EN` undefined**
  - The stats ports and logic are absent.
  - Datapath behaviour is identical.

## Test plan
- **Reset defaults:** reset high 3 cycles → `t_ready` = 1, `i_valid` = 0, stats = 0.
- **Single beat:** push 0xDEADBEEF at edge N with `i_ready` = 1 → `i_valid` = 1 and `i_dat` = 0xDEADBEEF after edge N; pop at edge N+1; `count` returns to 0.
- **Fill and drain:** `i_ready` = 0, push 0x1..0x4 (`DEPTH` = 4) → `t_ready` = 0 after the 4th push. A 5th `t_valid` beat is stalled. Raising `i_ready` yields 0x1, 0x2, 0x3, 0x4, then 0x5, in order.
- **Alternating backpressure:** 100 incrementing beats with consumer ready asserted every other cycle → all 100 received in order, none lost. With stats: `st_in_count` = `st_out_count` = 100.
- **Wrap-around:** `i_ready` = 1 constantly and 10 back-to-back beats → pointers wrap twice, data order is preserved, throughput is one beat per cycle after the first.
- **Reset mid-stream:** 3 beats held, reset for 1 cycle concurrent with `t_valid` → `count` = 0 and `i_valid` = 0 after reset; the beat offered during reset is not stored. With stats: `st_max_level` = 0.
